// File: rtl/ctrl_pipe_pkg.sv
// Shared defaults and control-bundle bit map for the MIPS control pipeline.
package ctrl_pipe_pkg;

  localparam int CTRL_W_DEF = 16;
  localparam int STAGES_DEF = 3;
  localparam int CNT_W_DEF  = 32;

  localparam int REGWRITE    = 0;
  localparam int MEMTOREG    = 1;
  localparam int MEMWRITE    = 2;
  localparam int ALUCTRL_LSB = 3;
  localparam int ALUCTRL_MSB = 5;
  localparam int DATAMOVE    = 6;
  localparam int WRITEHILO   = 7;
  localparam int HIORLO      = 8;

  // Packs individual decoded fields into a bundle; unlisted bits stay 0.
  function automatic logic [CTRL_W_DEF-1:0] mk_ctrl(
    input logic       regwrite,
    input logic       memtoreg,
    input logic       memwrite,
    input logic [2:0] aluctrl,
    input logic       datamove,
    input logic       writehilo,
    input logic       hiorlo
  );
    logic [CTRL_W_DEF-1:0] r;
    r = '0;
    r[REGWRITE]                  = regwrite;
    r[MEMTOREG]                  = memtoreg;
    r[MEMWRITE]                  = memwrite;
    r[ALUCTRL_MSB:ALUCTRL_LSB]   = aluctrl;
    r[DATAMOVE]                  = datamove;
    r[WRITEHILO]                 = writehilo;
    r[HIORLO]                    = hiorlo;
    return r;
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline stage: control bundle plus valid bit with flush/hold/bubble priority.
module ctrl_stage_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              hold,
  input  logic              bubble,
  input  logic [CTRL_W-1:0] d_ctrl,
  input  logic              d_valid,
  output logic [CTRL_W-1:0] q_ctrl,
  output logic              q_valid
);

  logic [CTRL_W-1:0] r_ctrl;
  logic              r_valid;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else if (hold) begin
      r_ctrl  <= r_ctrl;
      r_valid <= r_valid;
    end else if (bubble) begin
      r_ctrl  <= '0;
      r_valid <= 1'b0;
    end else begin
      // Invalid loads are zeroed so an empty stage never asserts a write enable.
      r_ctrl  <= d_valid ? d_ctrl : '0;
      r_valid <= d_valid;
    end
  end

  assign q_ctrl  = r_ctrl;
  assign q_valid = r_valid;

endmodule

// File: rtl/ctrl_pipe.sv
// Parametrised control-signal pipeline (Decode -> E/M/W) with upstream stall chain.
// Optional performance counters are built only when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int STAGES = STAGES_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CTRL_W-1:0]        ctrl_d,
  input  logic                     valid_d,
  input  logic [STAGES-1:0]        stall,
  input  logic [STAGES-1:0]        flush,
  output logic                     ready_d,
  output logic [STAGES*CTRL_W-1:0] ctrl_q,
  output logic [STAGES-1:0]        valid_q,
  output logic [CNT_W-1:0]         bubble_cnt,
  output logic [CNT_W-1:0]         flush_cnt
);

  logic [STAGES-1:0]             w_hold;
  logic [STAGES-1:0][CTRL_W-1:0] w_ctrl;
  logic [STAGES-1:0]             w_valid;

  // Holds ripple upstream only: a stalled stage freezes everything before it.
  assign w_hold[STAGES-1] = stall[STAGES-1];
  for (genvar i = 0; i < STAGES-1; i++) begin : g_hold
    assign w_hold[i] = stall[i] | w_hold[i+1];
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      ctrl_stage_reg #(.CTRL_W(CTRL_W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush[i]),
        .hold   (w_hold[i]),
        .bubble (1'b0),
        .d_ctrl (ctrl_d),
        .d_valid(valid_d),
        .q_ctrl (w_ctrl[i]),
        .q_valid(w_valid[i])
      );
    end else begin : g_rest
      ctrl_stage_reg #(.CTRL_W(CTRL_W)) u_stage (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush[i]),
        .hold   (w_hold[i]),
        .bubble (w_hold[i-1]),
        .d_ctrl (w_ctrl[i-1]),
        .d_valid(w_valid[i-1]),
        .q_ctrl (w_ctrl[i]),
        .q_valid(w_valid[i])
      );
    end
  end

  assign ready_d = ~w_hold[0];
  assign ctrl_q  = w_ctrl;
  assign valid_q = w_valid;

`ifdef CTRL_PIPE_PERF_EN
  logic [CNT_W-1:0] r_bubble_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Both counters saturate rather than wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      if (!w_valid[STAGES-1] && r_bubble_cnt != '1)
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      if (|(flush & w_valid) && r_flush_cnt != '1)
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
